// File: rtl/ts_pkg.sv
// Shared constants and state encoding for the MPEG2-TS packet synchroniser.
package ts_pkg;
  localparam int          TS_PKT_LEN   = 188;
  localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
  localparam int          TS_CNT_W     = $clog2(TS_PKT_LEN);

  typedef logic [1:0] ts_state_t;
  localparam ts_state_t HUNT   = 2'd0;
  localparam ts_state_t VERIFY = 2'd1;
  localparam ts_state_t LOCKED = 2'd2;
endpackage

// File: rtl/ts_sync_stats.sv
// Saturating packet / sync-error counters for ts_packet_sync (TS_SYNC_STATS_EN builds).
module ts_sync_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        pkt_inc,
  input  logic        err_inc,
  output logic [31:0] pkt_cnt,
  output logic [15:0] err_cnt
);
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (pkt_inc && (pkt_cnt_q != '1)) pkt_cnt_d = pkt_cnt_q + 32'd1;
    if (err_inc && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign err_cnt = err_cnt_q;
endmodule

// File: rtl/ts_packet_sync.sv
// MPEG2-TS sync finder: hunts for 0x47 every PKT_LEN bytes, locks, forwards aligned packets.
// Define TS_SYNC_STATS_EN to add the pkt_cnt / err_cnt statistics outputs.
module ts_packet_sync
  import ts_pkg::*;
#(
  parameter int              DATA_WIDTH   = 8,
  parameter int              PKT_LEN      = TS_PKT_LEN,
  parameter logic [7:0]      SYNC_BYTE    = TS_SYNC_BYTE,
  parameter int              LOCK_COUNT   = 3,
  parameter int              UNLOCK_COUNT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  sop,
  output logic                  eop,
  output logic                  locked,
  output logic                  sync_err,
  output logic                  sync_loss
`ifdef TS_SYNC_STATS_EN
  ,
  output logic [31:0]           pkt_cnt,
  output logic [15:0]           err_cnt
`endif
);
  localparam int         CNT_W    = $clog2(PKT_LEN);
  localparam logic [2:0] LOCK_N   = 3'(LOCK_COUNT);
  localparam logic [2:0] UNLOCK_N = 3'(UNLOCK_COUNT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PKT_LEN - 1);

  ts_state_t             state_q, state_d;
  logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [2:0]            good_cnt_q, good_cnt_d;
  logic [2:0]            miss_cnt_q, miss_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic                  locked_q, locked_d;
  logic                  err_q, err_d;
  logic                  loss_q, loss_d;

  logic is_sync, at_sync;
  logic [CNT_W-1:0] cnt_next;

  assign is_sync  = (data_in == SYNC_BYTE);
  assign at_sync  = (byte_cnt_q == '0);
  assign cnt_next = (byte_cnt_q == LAST) ? '0 : byte_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    good_cnt_d = good_cnt_q;
    miss_cnt_d = miss_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    err_d      = 1'b0;
    loss_d     = 1'b0;
    if (valid_in) begin
      byte_cnt_d = cnt_next;
      case (state_q)
        HUNT: begin
          byte_cnt_d = '0;
          if (is_sync) begin
            state_d    = VERIFY;
            byte_cnt_d = CNT_W'(1);
            good_cnt_d = 3'd1;
          end
        end
        VERIFY: begin
          if (at_sync) begin
            if (is_sync) begin
              good_cnt_d = good_cnt_q + 3'd1;
              if (good_cnt_d >= LOCK_N) begin
                // The confirming sync is itself the first forwarded byte.
                state_d    = LOCKED;
                good_cnt_d = '0;
                miss_cnt_d = '0;
                valid_d    = 1'b1;
                sop_d      = 1'b1;
                data_d     = data_in;
              end
            end else begin
              // Misaligned candidate; the offending byte is not re-tried as a sync.
              state_d    = HUNT;
              good_cnt_d = '0;
              byte_cnt_d = '0;
            end
          end
        end
        LOCKED: begin
          valid_d = 1'b1;
          data_d  = data_in;
          sop_d   = at_sync;
          eop_d   = (byte_cnt_q == LAST);
          if (at_sync) begin
            if (is_sync) begin
              miss_cnt_d = '0;
            end else if (miss_cnt_q + 3'd1 >= UNLOCK_N) begin
              // Lock loss happens only on a packet boundary; the boundary byte is dropped.
              state_d    = HUNT;
              byte_cnt_d = '0;
              good_cnt_d = '0;
              miss_cnt_d = '0;
              valid_d    = 1'b0;
              sop_d      = 1'b0;
              data_d     = data_q;
              loss_d     = 1'b1;
            end else begin
              miss_cnt_d = miss_cnt_q + 3'd1;
              err_d      = 1'b1;
            end
          end
        end
        default: begin
          state_d    = HUNT;
          byte_cnt_d = '0;
          good_cnt_d = '0;
          miss_cnt_d = '0;
        end
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      byte_cnt_q <= '0;
      good_cnt_q <= '0;
      miss_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      loss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      good_cnt_q <= good_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      loss_q     <= loss_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign sop       = sop_q;
  assign eop       = eop_q;
  assign locked    = locked_q;
  assign sync_err  = err_q;
  assign sync_loss = loss_q;

`ifdef TS_SYNC_STATS_EN
  ts_sync_stats u_stats (
    .clk     (clk),
    .rst     (rst),
    .pkt_inc (eop_d),
    .err_inc (err_d | loss_d),
    .pkt_cnt (pkt_cnt),
    .err_cnt (err_cnt)
  );
`endif
endmodule

// File: tb/tb_ts_packet_sync.sv
// Directed bench for ts_packet_sync: acquisition, false sync, errors, lock loss, gaps, mid-packet reset.
module tb_ts_packet_sync;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out, sop, eop, locked, sync_err, sync_loss;
`ifdef TS_SYNC_STATS_EN
  logic [31:0] pkt_cnt;
  logic [15:0] err_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int vcnt  = 0;
  logic lk_exp = 1'b0;

  always #5 clk = ~clk;

  ts_packet_sync dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .sop       (sop),
    .eop       (eop),
    .locked    (locked),
    .sync_err  (sync_err),
    .sync_loss (sync_loss)
`ifdef TS_SYNC_STATS_EN
    ,
    .pkt_cnt   (pkt_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Packed view {valid, data (masked when idle), sop, eop, sync_err, sync_loss, locked}.
  function automatic logic [31:0] obs();
    return {19'd0, valid_out, (valid_out ? data_out : 8'h00), sop, eop, sync_err, sync_loss, locked};
  endfunction

  function automatic logic [31:0] mk(input logic v, input logic [7:0] d, input logic s,
                                     input logic e, input logic er, input logic ls, input logic lk);
    return {19'd0, v, (v ? d : 8'h00), s, e, er, ls, lk};
  endfunction

  // One byte, optionally preceded by an idle cycle carrying a decoy 0x47.
  task automatic send1(input string tag, input logic [7:0] b, input bit gap, input logic [31:0] exp);
    if (gap && ($urandom_range(0, 1) == 1)) begin
      data_in  = 8'h47;
      valid_in = 1'b0;
      @(posedge clk); #1;
      chk({tag, " gap"}, obs(), mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, lk_exp));
    end
    data_in  = b;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    if (valid_out) vcnt++;
    chk(tag, obs(), exp);
    lk_exp = exp[0];
  endtask

  // Bytes lo..hi of a packet whose byte k is k, except byte 0 = b0.
  task automatic send_bytes(input string tag, input int lo, input int hi, input logic [7:0] b0,
                            input logic f0, input logic e0, input logic l0, input logic fwd,
                            input bit gap);
    for (int k = lo; k <= hi; k++) begin
      if (k == 0)
        send1($sformatf("%s b0", tag), b0, gap, mk(f0, b0, f0, 1'b0, e0, l0, f0));
      else
        send1($sformatf("%s b%0d", tag, k), 8'(k), gap,
              mk(fwd, 8'(k), 1'b0, fwd && (k == 187), 1'b0, 1'b0, fwd));
    end
  endtask

  task automatic send_pkt(input string tag, input logic [7:0] b0, input logic f0, input logic e0,
                          input logic l0, input logic fwd, input bit gap);
    send_bytes(tag, 0, 187, b0, f0, e0, l0, fwd, gap);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    lk_exp = 1'b0;
  endtask

  initial begin
    #1;
    do_reset();
    chk("reset_outputs", obs(), 32'd0);
    chk("reset_data", {24'd0, data_out}, 32'd0);
`ifdef TS_SYNC_STATS_EN
    chk("reset_pkt_cnt", pkt_cnt, 32'd0);
    chk("reset_err_cnt", {16'd0, err_cnt}, 32'd0);
`endif

    // Clean acquisition: lock on packet 3, packets 3..5 forwarded.
    vcnt = 0;
    send_pkt("clean1", 8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pkt("clean2", 8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pkt("clean3", 8'h47, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_pkt("clean4", 8'h47, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_pkt("clean5", 8'h47, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clean_valid_total", vcnt, 32'd564);

    // False sync at offset 1 is rejected at offset 189, true alignment locks on packet 4.
    do_reset();
    vcnt = 0;
    send1("junk0", 8'h12, 1'b0, 32'd0);
    send1("junk1", 8'h47, 1'b0, 32'd0);
    send_pkt("fs1", 8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pkt("fs2", 8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pkt("fs3", 8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fs_no_early_output", vcnt, 32'd0);
    send_pkt("fs4", 8'h47, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Single corrupt sync keeps lock; good sync clears the miss count.
    send_pkt("err1", 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send_pkt("good", 8'h47, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Three consecutive misses drop lock on the third boundary.
    send_pkt("miss1", 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send_pkt("miss2", 8'hB8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send_pkt("miss3", 8'h46, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef TS_SYNC_STATS_EN
    chk("err_cnt_after_loss", {16'd0, err_cnt}, 32'd4);
`endif

    // Idle gaps (with decoy 0x47 on data_in) must not disturb alignment or output.
    do_reset();
    send_pkt("gp1", 8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pkt("gp2", 8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pkt("gp3", 8'h47, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    vcnt = 0;
    for (int p = 0; p < 4; p++)
      send_pkt($sformatf("gap%0d", p), 8'h47, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("gap_valid_total", vcnt, 32'd752);

    // Mid-packet reset at byte 90, then re-acquisition.
    do_reset();
`ifdef TS_SYNC_STATS_EN
    chk("rst_pkt_cnt0", pkt_cnt, 32'd0);
`endif
    send_pkt("rs1", 8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pkt("rs2", 8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 5; p++)
      send_pkt($sformatf("rsl%0d", p), 8'h47, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef TS_SYNC_STATS_EN
    chk("pkt_cnt_5", pkt_cnt, 32'd5);
`endif
    send_bytes("part", 0, 89, 8'h47, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_outputs", obs(), 32'd0);
    chk("midrst_data", {24'd0, data_out}, 32'd0);
`ifdef TS_SYNC_STATS_EN
    chk("midrst_pkt_cnt", pkt_cnt, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    lk_exp = 1'b0;
    vcnt   = 0;
    send_bytes("tail", 91, 187, 8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tail_no_eop", vcnt, 32'd0);
    send_pkt("rl1", 8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pkt("rl2", 8'h47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_pkt("rl3", 8'h47, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
